dmem_port_arbiter: RTL

//   Shares the single-ported data memory between two requesters: port C (core load/store unit)
//   and port D (debug/loader/DMA). Each cycle it picks at most one winner and steers that port

---
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (C = core LSU, D = debug/loader)
// and the single-ported DMEM.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic          c_lock;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;

    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requester and memory side of the bundle
    modport master (
        output c_req, c_we, c_lock, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side of the bundle
    modport slave (
        input  c_req, c_we, c_lock, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter for a single-ported DMEM with a bounded lock, so one
// port can run short bursts; read data returns registered one cycle after the grant.
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    // Index 0 = port C, index 1 = port D
    logic [1:0]    req;
    logic [1:0]    we;
    logic [1:0]    lock;
    logic [1:0]    gnt;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    assign req      = {bus.d_req,  bus.c_req};
    assign we       = {bus.d_we,   bus.c_we};
    assign lock     = {bus.d_lock, bus.c_lock};
    assign addr[0]  = bus.c_addr;
    assign addr[1]  = bus.d_addr;
    assign wdata[0] = bus.c_wdata;
    assign wdata[1] = bus.d_wdata;

    logic          last_gnt_reg, last_gnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          gnt_any;
    logic          gnt_sel;
    logic          rvalid_reg [2];
    logic [DW-1:0] rdata_reg  [2];

    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (!rst) begin
            if (req[0] && !req[1]) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (req[1] && !req[0]) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end else if (&req) begin
                // Owner keeps the bus only while its lock budget lasts
                gnt_any = 1'b1;
                gnt_sel = (lock[last_gnt_reg] && (hold_cnt_reg < HW'(MAX_HOLD)))
                          ? last_gnt_reg : ~last_gnt_reg;
            end
        end
    end

    assign gnt       = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    assign bus.c_gnt = gnt[0];
    assign bus.d_gnt = gnt[1];

    assign bus.mem_write = gnt_any &  we[gnt_sel];
    assign bus.mem_read  = gnt_any & ~we[gnt_sel];
    assign bus.mem_addr  = gnt_any ? addr[gnt_sel]  : '0;
    assign bus.mem_wdata = gnt_any ? wdata[gnt_sel] : '0;

    always_comb begin
        last_gnt_next = last_gnt_reg;
        hold_cnt_next = '0;
        if (gnt_any) begin
            last_gnt_next = gnt_sel;
            if (gnt_sel == last_gnt_reg)
                hold_cnt_next = (hold_cnt_reg == HW'(MAX_HOLD)) ? hold_cnt_reg
                                                                : hold_cnt_reg + HW'(1);
            else
                hold_cnt_next = HW'(1);
        end
    end

    // Reset leaves D as last owner so C wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= 1'b1;
            hold_cnt_reg <= '0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= '0;
            end else begin
                rvalid_reg[gi] <= gnt[gi] & ~we[gi];
                if (gnt[gi] && !we[gi])
                    rdata_reg[gi] <= bus.mem_rdata;
            end
        end
    end

    assign bus.c_rvalid = rvalid_reg[0];
    assign bus.c_rdata  = rdata_reg[0];
    assign bus.d_rvalid = rvalid_reg[1];
    assign bus.d_rdata  = rdata_reg[1];
endmodule
